// File: rtl/rom_stream_if.sv
// Valid/ready stream carrying ROM words from the burst reader to its consumer.
interface rom_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/rom_stream_src.sv
// Reads a burst of words from a combinational ROM and streams them out over a
// valid/ready interface, one beat per cycle when the consumer never stalls.
module rom_stream_src #(
  parameter int                ADDR_W   = 13,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 'h0FF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  output logic              rom_ena,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  rom_stream_if.master      m
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;
  logic              fetch;
  logic              xfer;

  assign xfer  = m_valid_q && m.m_ready;
  // A fetch may refill the output register in the same cycle its beat leaves.
  assign fetch = (state_q == RUN) && (remaining_q != '0) && (!m_valid_q || m.m_ready);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    done_d      = 1'b0;

    if (xfer) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rom_addr_d  = start_addr;
          remaining_d = len;
          state_d     = (len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (fetch) begin
          // rom_data is only trusted here; outside fetch cycles it may float.
          m_data_d    = rom_data;
          m_valid_d   = 1'b1;
          m_last_d    = (remaining_q == ADDR_W'(1));
          rom_addr_d  = (rom_addr_q == MAX_ADDR) ? '0 : rom_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) state_d = DRAIN;
        end else if (remaining_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Any beat still held here is the last one of the burst.
        if (!m_valid_q || m.m_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign rom_ena   = busy;
  assign rom_read  = fetch;
  assign rom_addr  = rom_addr_q;
  assign done      = done_q;
  assign m.m_data  = m_data_q;
  assign m.m_valid = m_valid_q;
  assign m.m_last  = m_last_q;

endmodule

// File: doc/rom_stream_src.md
ROM_STREAM_SRC -- requirements
Module: rom_stream_src

Interface
REQ-001 Parameter ADDR_W, default 13, ROM address width.
REQ-002 Parameter DATA_W, default 8, ROM data width.
REQ-003 Parameter MAX_ADDR, default 13'h0FF, highest valid ROM address; address wraps to 0 after it.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 start_addr  input  ADDR_W  first ROM address of the burst; sampled with start.
REQ-008 len  input  ADDR_W  number of beats in the burst; sampled with start.
REQ-009 rom_addr  output  ADDR_W  address presented to the ROM.
REQ-010 rom_read  output  1  ROM read strobe; high only in fetch cycles.
REQ-011 rom_ena  output  1  ROM enable; high while busy.
REQ-012 rom_data  input  DATA_W  combinational ROM read data; may be Z when rom_read or rom_ena is low.
REQ-013 m_data  output  DATA_W  stream data.
REQ-014 m_valid  output  1  stream data valid.
REQ-015 m_ready  input  1  downstream ready.
REQ-016 m_last  output  1  marks the final beat of the burst; qualified by m_valid.
REQ-017 busy  output  1  high from the cycle after an accepted start until done.
REQ-018 done  output  1  one-cycle pulse at burst completion.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-020 IDLE->RUN on start=1: latch rom_addr<=start_addr, remaining<=len.
REQ-021 IDLE->DRAIN on start=1 with len=0; no beats are produced.
REQ-022 start while not IDLE SHALL be ignored.
REQ-023 Fetch condition: state=RUN, remaining!=0, and (m_valid=0 or m_ready=1).
REQ-024 On fetch: m_data<=rom_data, m_valid<=1, m_last<=(remaining==1), rom_addr advances, remaining decrements.
REQ-025 rom_addr advance: MAX_ADDR -> 0, otherwise +1; wrap is transparent to the stream.
REQ-026 rom_data SHALL be sampled only in fetch cycles; Z at other times is never captured.
REQ-027 Beat is transferred when m_valid=1 and m_ready=1; m_valid is cleared unless a fetch occurs in the same cycle.
REQ-028 m_data, m_last and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-029 Throughput: one beat per cycle when m_ready is held high; no bubbles within a burst.
REQ-030 Latency: start accepted at edge N gives first m_valid=1 after edge N+1, carrying ROM[start_addr].
REQ-031 RUN->DRAIN when remaining reaches 0.
REQ-032 DRAIN->IDLE when m_valid=0, or when the last beat transfers; done=1 for exactly that one cycle.
REQ-033 In the cycle after DRAIN->IDLE, busy=0 and a new start is accepted.
REQ-034 rom_ena=busy; rom_read=1 only in fetch cycles.
REQ-035 remaining is ADDR_W bits; len up to 2^ADDR_W-1 is supported.

Reset
REQ-036 rst_n=0 SHALL immediately force state=IDLE, rom_addr=0, remaining=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, rom_read=0, rom_ena=0.
REQ-037 Reset mid-burst SHALL abort the burst without a done pulse; untransferred beats are discarded.
REQ-038 The first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-039 ROM loaded with ROM[i]=i; start_addr=0x00, len=4, m_ready=1 -> beats 00,01,02,03 on consecutive cycles, m_last on 03, then one done pulse.
REQ-040 start_addr=0xFE, len=4, MAX_ADDR=0xFF -> beats FE,FF,00,01; rom_addr wraps 0xFF->0x00.
REQ-041 len=3, m_ready toggled 1,0,0,1,... -> beats 00,01,02 with no loss or duplication; m_data held while stalled.
REQ-042 len=0 -> no m_valid; done pulses once, 2 cycles after start.
REQ-043 rst_n pulled low after the 2nd beat of len=8 -> all outputs 0 immediately, no done; a new start with len=2 produces 2 beats.
REQ-044 start asserted while busy -> ignored; burst length and addresses unchanged.
